// File: rtl/count_tracker.sv
// Tracks an upstream 4-bit up/down counter: step direction, wrap counts,
// single-entry event register with overflow flag, and direction-mismatch flag.
module count_tracker #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  input  logic              mode_in,
  input  logic [3:0]        threshold,
  input  logic              clr,
  input  logic              evt_ack,
  output logic              dir,
  output logic [WRAP_W-1:0] wrap_up_cnt,
  output logic [WRAP_W-1:0] wrap_dn_cnt,
  output logic              evt_valid,
  output logic [1:0]        evt_code,
  output logic              evt_ovf,
  output logic              err_dir
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CODE_W = 2;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;
  localparam logic [CODE_W-1:0] EVT_MATCH = 2'b00;
  localparam logic [CODE_W-1:0] EVT_WUP   = 2'b01;
  localparam logic [CODE_W-1:0] EVT_WDN   = 2'b10;
  localparam logic [CODE_W-1:0] EVT_JUMP  = 2'b11;

  logic [CNT_W-1:0]  r_prev;
  logic              r_mode_d;
  logic              r_prev_ok;
  logic              r_dir;
  logic [WRAP_W-1:0] r_wrap_up;
  logic [WRAP_W-1:0] r_wrap_dn;
  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_evt_ovf;
  logic              r_err_dir;

  logic [CNT_W-1:0]  w_delta;
  logic              w_up;
  logic              w_dn;
  logic              w_jump;
  logic              w_wrap_up;
  logic              w_wrap_dn;
  logic              w_match;
  logic              w_offer;
  logic [CODE_W-1:0] w_code;

  logic              w_dir_nxt;
  logic [WRAP_W-1:0] w_wrap_up_nxt;
  logic [WRAP_W-1:0] w_wrap_dn_nxt;
  logic              w_evt_valid_nxt;
  logic [CODE_W-1:0] w_evt_code_nxt;
  logic              w_evt_ovf_nxt;
  logic              w_err_dir_nxt;

  // Step classification; the first sample after reset only primes r_prev.
  always_comb begin
    w_delta   = count_in - r_prev;
    w_up      = r_prev_ok && (w_delta == CNT_W'(1));
    w_dn      = r_prev_ok && (w_delta == CNT_MAX);
    w_jump    = r_prev_ok && (w_delta != CNT_W'(0)) && !w_up && !w_dn;
    w_wrap_up = r_prev_ok && (r_prev == CNT_MAX) && (count_in == CNT_W'(0));
    w_wrap_dn = r_prev_ok && (r_prev == CNT_W'(0)) && (count_in == CNT_MAX);
    w_match   = (count_in == threshold) && (r_prev != threshold);
  end

  // Single offered event per cycle: jump > wrap > match.
  always_comb begin
    w_offer = 1'b0;
    w_code  = EVT_MATCH;
    if (w_jump) begin
      w_offer = 1'b1;
      w_code  = EVT_JUMP;
    end else if (w_wrap_up) begin
      w_offer = 1'b1;
      w_code  = EVT_WUP;
    end else if (w_wrap_dn) begin
      w_offer = 1'b1;
      w_code  = EVT_WDN;
    end else if (w_match) begin
      w_offer = 1'b1;
      w_code  = EVT_MATCH;
    end
  end

  // Next-state for direction, saturating wrap counters and sticky flags.
  always_comb begin
    w_dir_nxt       = r_dir;
    w_wrap_up_nxt   = r_wrap_up;
    w_wrap_dn_nxt   = r_wrap_dn;
    w_err_dir_nxt   = r_err_dir;
    w_evt_valid_nxt = r_evt_valid;
    w_evt_code_nxt  = r_evt_code;
    w_evt_ovf_nxt   = r_evt_ovf;

    if (w_up) begin
      w_dir_nxt = 1'b1;
    end else if (w_dn) begin
      w_dir_nxt = 1'b0;
    end

    if (w_wrap_up && (r_wrap_up != WRAP_MAX)) begin
      w_wrap_up_nxt = r_wrap_up + WRAP_W'(1);
    end
    if (w_wrap_dn && (r_wrap_dn != WRAP_MAX)) begin
      w_wrap_dn_nxt = r_wrap_dn + WRAP_W'(1);
    end

    if ((w_up && !r_mode_d) || (w_dn && r_mode_d)) begin
      w_err_dir_nxt = 1'b1;
    end

    // An acknowledge frees the slot in the same cycle a new event arrives.
    if (w_offer) begin
      if (!r_evt_valid || evt_ack) begin
        w_evt_valid_nxt = 1'b1;
        w_evt_code_nxt  = w_code;
      end else begin
        w_evt_ovf_nxt = 1'b1;
      end
    end else if (evt_ack) begin
      w_evt_valid_nxt = 1'b0;
    end

    // Clear beats any same-cycle increment or flag set; event slot untouched.
    if (clr) begin
      w_wrap_up_nxt = '0;
      w_wrap_dn_nxt = '0;
      w_err_dir_nxt = 1'b0;
      w_evt_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev      <= '0;
      r_mode_d    <= 1'b1;
      r_prev_ok   <= 1'b0;
      r_dir       <= 1'b1;
      r_wrap_up   <= '0;
      r_wrap_dn   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_code  <= EVT_MATCH;
      r_evt_ovf   <= 1'b0;
      r_err_dir   <= 1'b0;
    end else begin
      r_prev      <= count_in;
      r_mode_d    <= mode_in;
      r_prev_ok   <= 1'b1;
      r_dir       <= w_dir_nxt;
      r_wrap_up   <= w_wrap_up_nxt;
      r_wrap_dn   <= w_wrap_dn_nxt;
      r_evt_valid <= w_evt_valid_nxt;
      r_evt_code  <= w_evt_code_nxt;
      r_evt_ovf   <= w_evt_ovf_nxt;
      r_err_dir   <= w_err_dir_nxt;
    end
  end

  assign dir         = r_dir;
  assign wrap_up_cnt = r_wrap_up;
  assign wrap_dn_cnt = r_wrap_dn;
  assign evt_valid   = r_evt_valid;
  assign evt_code    = r_evt_code;
  assign evt_ovf     = r_evt_ovf;
  assign err_dir     = r_err_dir;

endmodule

// File: tb/tb_count_tracker.sv
// Directed vector bench for count_tracker: a default-width instance and a
// 2-bit-counter instance share stimulus; the latter exercises saturation.
module tb_count_tracker;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic       mode_in;
  logic [3:0] threshold;
  logic       clr;
  logic       evt_ack;

  logic       dir8, evt_valid8, evt_ovf8, err_dir8;
  logic [7:0] wup8, wdn8;
  logic [1:0] evt_code8;

  logic       dir2, evt_valid2, evt_ovf2, err_dir2;
  logic [1:0] wup2, wdn2;
  logic [1:0] evt_code2;

  count_tracker #(.WRAP_W(8)) dut8 (
    .clk(clk), .rst(rst), .count_in(count_in), .mode_in(mode_in),
    .threshold(threshold), .clr(clr), .evt_ack(evt_ack),
    .dir(dir8), .wrap_up_cnt(wup8), .wrap_dn_cnt(wdn8),
    .evt_valid(evt_valid8), .evt_code(evt_code8), .evt_ovf(evt_ovf8),
    .err_dir(err_dir8)
  );

  count_tracker #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in), .mode_in(mode_in),
    .threshold(threshold), .clr(clr), .evt_ack(evt_ack),
    .dir(dir2), .wrap_up_cnt(wup2), .wrap_dn_cnt(wdn2),
    .evt_valid(evt_valid2), .evt_code(evt_code2), .evt_ovf(evt_ovf2),
    .err_dir(err_dir2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rst_n, cnt, mode, thr, clr, ack;
    int e_dir, e_wup, e_wdn, e_val, e_code, e_ovf, e_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input int r, input int c, input int m, input int t,
                     input int cl, input int a, input int d, input int wu,
                     input int wd, input int v, input int cd, input int o,
                     input int e);
    vec_t x;
    x.rst_n = r; x.cnt = c; x.mode = m; x.thr = t; x.clr = cl; x.ack = a;
    x.e_dir = d; x.e_wup = wu; x.e_wdn = wd; x.e_val = v; x.e_code = cd;
    x.e_ovf = o; x.e_err = e;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic step(input vec_t v);
    rst       = v.rst_n[0];
    count_in  = v.cnt[3:0];
    mode_in   = v.mode[0];
    threshold = v.thr[3:0];
    clr       = v.clr[0];
    evt_ack   = v.ack[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; count_in = 4'd0; mode_in = 1'b1; threshold = 4'd5;
    clr = 1'b0; evt_ack = 1'b1;

    // Reset, then count up 0..15,0,1 with ack held: one match, one wrap-up
    add(0, 0, 1, 5, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 5, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c < 16; c++)
      add(1, c, 1, 5, 0, 1,  1, 0, 0, (c == 5) ? 1 : 0, 0, 0, 0);
    add(1, 0, 1, 5, 0, 1,  1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 1, 5, 0, 1,  1, 1, 0, 0, 1, 0, 0);
    // Count down 2,1,0,15,14 with mode 0: one wrap-down event
    add(1, 2, 0, 5, 0, 1,  1, 1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 5, 0, 1,  0, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 5, 0, 1,  0, 1, 0, 0, 1, 0, 0);
    add(1, 15, 0, 5, 0, 1, 0, 1, 1, 1, 2, 0, 0);
    add(1, 14, 0, 5, 0, 1, 0, 1, 1, 0, 2, 0, 0);
    // threshold 0, no ack: wrap beats match, then a jump overflows
    add(1, 14, 1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0);
    add(1, 15, 1, 0, 0, 0, 1, 1, 1, 0, 2, 0, 0);
    add(1, 0, 1, 0, 0, 0,  1, 2, 1, 1, 1, 0, 0);
    add(1, 5, 1, 0, 0, 0,  1, 2, 1, 1, 1, 1, 0);
    // Jumps load over a valid event when acked; up-step against mode 0
    add(1, 3, 1, 0, 0, 1,  1, 2, 1, 1, 3, 1, 0);
    add(1, 9, 1, 0, 0, 1,  1, 2, 1, 1, 3, 1, 0);
    add(1, 4, 0, 0, 0, 1,  1, 2, 1, 1, 3, 1, 0);
    add(1, 5, 0, 0, 0, 1,  1, 2, 1, 0, 3, 1, 1);
    add(1, 5, 0, 0, 1, 1,  1, 0, 0, 0, 3, 0, 0);
    // dir held through jumps; clr discards same-cycle wrap and error
    add(1, 4, 0, 0, 0, 1,  0, 0, 0, 0, 3, 0, 0);
    add(1, 12, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0);
    add(1, 15, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0);
    add(1, 0, 1, 0, 1, 1,  1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0);
    // Four wrap-ups via jumps: narrow instance saturates
    for (int k = 1; k <= 4; k++) begin
      add(1, 8, 1, 0, 0, 1,  1, k - 1, 0, 1, 3, 0, 0);
      add(1, 15, 1, 0, 0, 1, 1, k - 1, 0, 1, 3, 0, 0);
      add(1, 0, 1, 0, 0, 1,  1, k, 0, 1, 1, 0, 0);
    end
    // Reset while an event is pending; first sample 15 must not wrap/jump
    add(0, 0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    add(1, 15, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 15, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i]);
      chk("dir",       i, 32'(dir8),       32'(vecs[i].e_dir));
      chk("wrap_up",   i, 32'(wup8),       32'(vecs[i].e_wup));
      chk("wrap_dn",   i, 32'(wdn8),       32'(vecs[i].e_wdn));
      chk("evt_valid", i, 32'(evt_valid8), 32'(vecs[i].e_val));
      chk("evt_code",  i, 32'(evt_code8),  32'(vecs[i].e_code));
      chk("evt_ovf",   i, 32'(evt_ovf8),   32'(vecs[i].e_ovf));
      chk("err_dir",   i, 32'(err_dir8),   32'(vecs[i].e_err));
      chk("wrap_up_w2", i, 32'(wup2),      32'(sat3(vecs[i].e_wup)));
      chk("wrap_dn_w2", i, 32'(wdn2),      32'(sat3(vecs[i].e_wdn)));
    end

    // Four wrap-downs (15 -> 8 -> 0 -> 15) in mode 0
    for (int k = 0; k < 4; k++) begin
      rst = 1'b1; mode_in = 1'b0; threshold = 4'd0; clr = 1'b0; evt_ack = 1'b1;
      count_in = 4'd8;  @(posedge clk); #1;
      count_in = 4'd0;  @(posedge clk); #1;
      count_in = 4'd15; @(posedge clk); #1;
    end
    chk("seq_wdn_w8",  100, 32'(wdn8),       32'd4);
    chk("seq_wdn_w2",  100, 32'(wdn2),       32'd3);
    chk("seq_dir",     100, 32'(dir8),       32'd0);
    chk("seq_err",     100, 32'(err_dir8),   32'd0);
    chk("seq_code",    100, 32'(evt_code8),  32'd2);
    chk("seq_valid",   100, 32'(evt_valid8), 32'd1);

    // Reset between clock edges must clear state without waiting for clk
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 101, 32'(evt_valid8), 32'd0);
    chk("async_wdn",   101, 32'(wdn8),       32'd0);
    chk("async_dir",   101, 32'(dir8),       32'd1);
    chk("async_code",  101, 32'(evt_code8),  32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_tracker.md
COUNT_TRACKER -- requirements
Module: count_tracker

Interface
REQ-001 Parameter WRAP_W, default 8: width of each wrap-event counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately.
REQ-004 count_in  input  4  count sampled from the upstream up/down counter.
REQ-005 mode_in  input  1  direction command driven to that counter: 1 = up, 0 = down.
REQ-006 threshold  input  4  match value compared against count_in.
REQ-007 clr  input  1  synchronous clear of wrap counters and sticky flags.
REQ-008 evt_ack  input  1  consumer accepts the presented event.
REQ-009 dir  output  1  direction of last observed step: 1 = up, 0 = down.
REQ-010 wrap_up_cnt  output  WRAP_W  number of 15->0 transitions seen.
REQ-011 wrap_dn_cnt  output  WRAP_W  number of 0->15 transitions seen.
REQ-012 evt_valid  output  1  event register holds an unacknowledged event.
REQ-013 evt_code  output  2  00 match, 01 wrap-up, 10 wrap-down, 11 jump.
REQ-014 evt_ovf  output  1  sticky: an event was dropped because the register was full.
REQ-015 err_dir  output  1  sticky: step direction disagreed with the commanded mode.

Function
REQ-016 Block SHALL register count_in into prev each cycle and mode_in into mode_d each cycle; prev_ok SHALL be set 1 after the first post-reset sample.
REQ-017 While prev_ok = 0, no step classification SHALL occur (first sample only primes prev).
REQ-018 Step classification SHALL use delta = (count_in - prev) mod 16: 0 hold, 1 up-step, 15 down-step, any other value jump.
REQ-019 Up-step SHALL set dir = 1; down-step SHALL set dir = 0; hold and jump SHALL leave dir unchanged.
REQ-020 Wrap-up SHALL be detected when prev = 15 and count_in = 0; wrap-down when prev = 0 and count_in = 15.
REQ-021 Each wrap counter SHALL increment by 1 on its wrap event and saturate at 2^WRAP_W-1 (no roll-over).
REQ-022 Match SHALL fire for one cycle only when count_in = threshold and prev != threshold (entry edge); it is not gated by prev_ok.
REQ-023 err_dir SHALL set when an up-step occurs with mode_d = 0 or a down-step occurs with mode_d = 1; hold and jump SHALL NOT set it.
REQ-024 Event priority within a cycle SHALL be jump > wrap > match; only the highest-priority event is offered.
REQ-025 Event load: if an event is offered and (evt_valid = 0 or evt_ack = 1), evt_code SHALL load and evt_valid SHALL be 1 next cycle.
REQ-026 If evt_valid = 1, evt_ack = 0 and an event is offered, the event SHALL be dropped, evt_code held, evt_ovf set.
REQ-027 If evt_ack = 1 and no event is offered, evt_valid SHALL clear next cycle; evt_ack with evt_valid = 0 SHALL be ignored.
REQ-028 clr = 1 SHALL zero wrap_up_cnt, wrap_dn_cnt, evt_ovf, err_dir next cycle; a wrap in the same cycle SHALL be discarded (clr wins); evt path, prev and dir SHALL be unaffected.
REQ-029 Outputs SHALL all be registered; event and counter updates appear one cycle after the triggering count_in sample.

Reset
REQ-030 On rst = 0: dir = 1, wrap_up_cnt = 0, wrap_dn_cnt = 0, evt_valid = 0, evt_code = 00, evt_ovf = 0, err_dir = 0, prev = 0, mode_d = 1, prev_ok = 0.
REQ-031 Reset asserted mid-operation SHALL discard any pending event without acknowledgement; after release, first sample re-primes prev (no spurious jump or wrap).

Verification
REQ-032 Reset, mode_in = 1, count_in 0..15,0,1 one per cycle, evt_ack = 1 -> wrap_up_cnt = 1, dir = 1, err_dir = 0, one wrap-up event (01).
REQ-033 count_in 2,1,0,15,14 with mode_in = 0 -> wrap_dn_cnt = 1, dir = 0, evt_code 10 offered once.
REQ-034 threshold = 0, count_in 15->0 with evt_ack = 0 held -> evt_code = 01 (wrap beats match), evt_valid = 1; next offered event sets evt_ovf = 1, evt_code stays 01.
REQ-035 count_in 3->9 -> evt_code = 11, dir unchanged; count_in 4->5 with mode_in = 0 previous cycle -> err_dir = 1; clr = 1 -> err_dir = 0.
REQ-036 WRAP_W = 2, four wrap-ups -> wrap_up_cnt = 3 (saturated); rst pulse while evt_valid = 1 -> evt_valid = 0 and no event on first post-reset sample.
